uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: DATA_WIDTH, 8, payload bits per frame.
REQ-002 Port: CLK  input  1  system clock; every sequential element is on its rising edge.
REQ-003 Port: RST  input  1  asynchronous active-low reset.
REQ-004 Port: RX_IN  input  1  serial line, asynchronous to CLK, idles high.
REQ-005 Port: PAR_EN  input  1  1 = frame carries a parity bit.
REQ-006 Port: PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-007 Port: Prescale  input  6  CLK cycles per bit; 8, 16 or 32.
REQ-008 Port: P_DATA  output  DATA_WIDTH  last good received byte.
REQ-009 Port: Data_Valid  output  1  one-cycle pulse when P_DATA is updated.
REQ-010 Port: Par_Err  output  1  one-cycle pulse on a parity mismatch.
REQ-011 Port: Stp_Err  output  1  one-cycle pulse on a low stop bit.

Function
REQ-012 RX_IN SHALL pass through a two-flop synchronizer; all timing below refers to the synchronized signal.
REQ-013 The frame SHALL be: start bit 0, then DATA_WIDTH data bits LSB first, then parity if PAR_EN, then one stop bit 1.
REQ-014 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-015 IDLE -> START SHALL occur on the first cycle the synchronized RX_IN is 0; the edge counter is 0 in that cycle.
REQ-016 Prescale, PAR_EN and PAR_TYP SHALL be latched on the IDLE->START transition and held for the frame; a Prescale value outside {8,16,32} SHALL be treated as 8.
REQ-017 The edge counter SHALL count 0..Prescale-1 and then wrap to 0; each wrap advances the bit counter.
REQ-018 The bit value SHALL be the 2-of-3 majority of the samples at edge counts P/2-1, P/2 and P/2+1 (P = latched Prescale), and it is decided at count P/2+1.
REQ-019 START: a majority of 1 SHALL be treated as a glitch: return to IDLE with no output pulse and P_DATA unchanged.
REQ-020 DATA: after the last data bit wraps, the FSM SHALL go to PARITY if PAR_EN is 1, otherwise to STOP.
REQ-021 PARITY: the received bit SHALL be compared with the XOR of the data bits (inverted when PAR_TYP = 1); a mismatch is recorded.
REQ-022 STOP: the outcome SHALL be resolved on the cycle after the stop majority is decided, and the FSM returns to IDLE on that same cycle.
- The remaining half stop bit leaves margin so a following start edge is caught.
REQ-023 Good frame (stop = 1, no parity error): P_DATA SHALL be loaded and Data_Valid pulsed in that resolve cycle.
REQ-024 Parity error: Par_Err SHALL pulse, with no Data_Valid and P_DATA held.
REQ-025 Stop error: Stp_Err SHALL pulse, with no Data_Valid and P_DATA held.
REQ-026 Parity and stop errors together: Par_Err and Stp_Err SHALL pulse in the same cycle.
REQ-027 P_DATA SHALL hold its value until the next good frame.
REQ-028 Back-to-back frames with no idle gap SHALL be received without loss.
REQ-029 Input changes mid-frame SHALL have no effect until the next frame starts.

Reset
REQ-030 When RST is low, asynchronously: the FSM SHALL be in IDLE; the counters, synchronizer (to 1), shift register and latched configuration SHALL be cleared; P_DATA = 0; Data_Valid = Par_Err = Stp_Err = 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no output pulse.
REQ-032 After reset is released, reception SHALL resume at the next falling edge of RX_IN.

Structure
REQ-033 Package uart_pkg SHALL hold the state encoding, the supported Prescale constants (8/16/32) and the default DATA_WIDTH.
REQ-034 The edge/bit counter SHALL be the sub-module edge_bit_counter (inputs: enable, latched Prescale; outputs: edge_cnt, bit_cnt).
REQ-035 Sampling, the shift register, the parity check and the FSM SHALL stay in uart_rx.

Verification
REQ-036 Prescale=8, PAR_EN=0, frame 0xA5 -> a single Data_Valid pulse with P_DATA = 0xA5, and no error pulses.
REQ-037 Prescale=16, even parity, 0x3C with parity bit 0 -> Data_Valid with P_DATA = 0x3C; repeat with parity bit 1 -> Par_Err only, P_DATA stays 0x3C.
REQ-038 Prescale=32, frame 0x81 with stop bit 0 -> Stp_Err only, no Data_Valid.
REQ-039 A 2-cycle low glitch on an idle line at Prescale=16 -> no pulses and FSM back in IDLE; a single-cycle spike inside a data bit -> the byte is still received correctly.
REQ-040 Three back-to-back frames 0x00, 0xFF, 0x55 at Prescale=8 -> three Data_Valid pulses with the matching P_DATA values.
REQ-041 RST pulsed low mid-DATA -> outputs go to 0 immediately; the next frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM encoding, supported bit
// periods and small combinational helpers.
package uart_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  // Unsupported bit periods fall back to the shortest one.
  function automatic logic [5:0] norm_prescale(input logic [5:0] p);
    case (p)
      PRESCALE_8, PRESCALE_16, PRESCALE_32: return p;
      default:                              return PRESCALE_8;
    endcase
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Bundle of the receiver's serial input, frame configuration and result
// outputs, for environments that drive or observe the receiver as a unit.
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic                  RX_IN;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [5:0]            Prescale;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  Par_Err;
  logic                  Stp_Err;

  modport master (
    output RX_IN, PAR_EN, PAR_TYP, Prescale,
    input  P_DATA, Data_Valid, Par_Err, Stp_Err
  );

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP, Prescale,
    output P_DATA, Data_Valid, Par_Err, Stp_Err
  );
endinterface

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling counter: edge_cnt runs 0..prescale-1 within a bit, bit_cnt
// counts completed bits. Both return to 0 whenever enable drops.
module edge_bit_counter #(
  parameter int BIT_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable_i,
  input  logic [5:0]           prescale_i,
  output logic [5:0]           edge_cnt_o,
  output logic [BIT_CNT_W-1:0] bit_cnt_o
);

  logic [5:0]           edge_cnt_q;
  logic [BIT_CNT_W-1:0] bit_cnt_q;

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else if (!enable_i) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else if (edge_cnt_q == prescale_i - 6'd1) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= bit_cnt_q + 1'b1;
    end else begin
      edge_cnt_q <= edge_cnt_q + 6'd1;
    end
  end

  assign edge_cnt_o = edge_cnt_q;
  assign bit_cnt_o  = bit_cnt_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizes RX_IN, majority-samples each bit mid-period,
// checks optional parity and the stop bit, and pulses the frame outcome.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Par_Err,
  output logic                  Stp_Err
);

  localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 3);

  rx_state_e             state_q, state_d;
  logic [1:0]            rx_sync_q;
  logic [5:0]            presc_q, presc_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [1:0]            samp_q, samp_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_err_q, par_err_d;
  logic                  stop_q, stop_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  dv_q, dv_d, pe_q, pe_d, se_q, se_d;

  logic                  rx_s, maj, cnt_en, wrap, last_data;
  logic [5:0]            edge_cnt, half;
  logic [BIT_CNT_W-1:0]  bit_cnt;

  assign rx_s      = rx_sync_q[1];
  assign half      = presc_q >> 1;
  assign wrap      = (edge_cnt == presc_q - 6'd1);
  assign last_data = (bit_cnt == BIT_CNT_W'(DATA_WIDTH));
  assign maj       = majority3(samp_q[0], samp_q[1], rx_s);
  // Counting starts in the cycle that leaves IDLE and clears the cycle it returns.
  assign cnt_en    = (state_d != IDLE);

  edge_bit_counter #(.BIT_CNT_W(BIT_CNT_W)) u_cnt (
    .clk        (CLK),
    .rst_n      (RST),
    .enable_i   (cnt_en),
    .prescale_i (presc_q),
    .edge_cnt_o (edge_cnt),
    .bit_cnt_o  (bit_cnt)
  );

  // NOTE: every variable gets its default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    samp_d    = samp_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    stop_d    = stop_q;
    p_data_d  = p_data_q;
    dv_d      = 1'b0;
    pe_d      = 1'b0;
    se_d      = 1'b0;

    if (state_q != IDLE) begin
      if (edge_cnt == half - 6'd1) samp_d[0] = rx_s;
      if (edge_cnt == half)        samp_d[1] = rx_s;
    end

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d   = START;
          presc_d   = norm_prescale(Prescale);
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          par_err_d = 1'b0;
        end
      end
      START: begin
        if (edge_cnt == half + 6'd1 && maj) state_d = IDLE;
        else if (wrap)                      state_d = DATA;
      end
      DATA: begin
        if (edge_cnt == half + 6'd1) shift_d = {maj, shift_q[DATA_WIDTH-1:1]};
        if (wrap && last_data)       state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (edge_cnt == half + 6'd1) par_err_d = (maj != (^shift_q ^ par_typ_q));
        if (wrap)                    state_d   = STOP;
      end
      STOP: begin
        if (edge_cnt == half + 6'd1) stop_d = maj;
        // Resolve one cycle after the stop decision, leaving half a bit of margin.
        if (edge_cnt == half + 6'd2) begin
          state_d = IDLE;
          if (stop_q && !par_err_q) begin
            p_data_d = shift_q;
            dv_d     = 1'b1;
          end else begin
            pe_d = par_err_q;
            se_d = !stop_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      rx_sync_q <= 2'b11;
      presc_q   <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      samp_q    <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      stop_q    <= 1'b0;
      p_data_q  <= '0;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      se_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_sync_q <= {rx_sync_q[0], RX_IN};
      presc_q   <= presc_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      samp_q    <= samp_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      stop_q    <= stop_d;
      p_data_q  <= p_data_d;
      dv_q      <= dv_d;
      pe_q      <= pe_d;
      se_q      <= se_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign Data_Valid = dv_q;
  assign Par_Err    = pe_q;
  assign Stp_Err    = se_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a frame table plus hand-built corner
// sequences, with outcome pulses checked against a scoreboard queue.
module tb_uart_rx;
  import uart_pkg::*;

  typedef struct {
    logic [2:0] flags;   // {Data_Valid, Par_Err, Stp_Err}
    logic [7:0] pdata;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic [5:0] presc;
    logic       par_en;
    logic       par_typ;
    logic       bad_par;
    logic       stop_bit;
    logic       scramble;
    logic [2:0] exp_flags;
    logic [7:0] exp_pdata;
  } vec_t;

  logic CLK;
  logic RST;
  int   n_pass  = 0;
  int   n_total = 0;
  logic [7:0] last_good = 8'h00;
  exp_t exp_q[$];

  uart_rx_if #(.DATA_WIDTH(8)) tif ();

  uart_rx #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (tif.RX_IN),
    .PAR_EN     (tif.PAR_EN),
    .PAR_TYP    (tif.PAR_TYP),
    .Prescale   (tif.Prescale),
    .P_DATA     (tif.P_DATA),
    .Data_Valid (tif.Data_Valid),
    .Par_Err    (tif.Par_Err),
    .Stp_Err    (tif.Stp_Err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard: every outcome pulse must match the oldest pending expectation.
  always @(negedge CLK) begin
    if (RST && (tif.Data_Valid || tif.Par_Err || tif.Stp_Err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {29'd0, tif.Data_Valid, tif.Par_Err, tif.Stp_Err}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_flags", {29'd0, tif.Data_Valid, tif.Par_Err, tif.Stp_Err}, {29'd0, e.flags});
        check("pulse_pdata", {24'd0, tif.P_DATA}, {24'd0, e.pdata});
      end
    end
  end

  initial begin
    repeat (100000) @(posedge CLK);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic drive(input logic v);
    tif.RX_IN = v;
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [2:0] flags, input logic [7:0] pdata);
    exp_t e;
    e.flags = flags;
    e.pdata = pdata;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic [5:0] presc,
                            input logic par_en, input logic par_typ, input logic bad_par,
                            input logic stop_bit, input logic scramble,
                            input int spike_bit, input int spike_off);
    logic bits[11];
    int   n_bits;
    int   bit_len;
    bit_len = (presc == 6'd8 || presc == 6'd16 || presc == 6'd32) ? int'(presc) : 8;
    tif.Prescale = presc;
    tif.PAR_EN   = par_en;
    tif.PAR_TYP  = par_typ;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = data[i];
    n_bits = 9;
    if (par_en) begin
      bits[n_bits] = (^data) ^ par_typ ^ bad_par;
      n_bits++;
    end
    bits[n_bits] = stop_bit;
    n_bits++;
    for (int b = 0; b < n_bits; b++) begin
      if (scramble && b == 1) begin
        tif.Prescale = 6'd32;
        tif.PAR_EN   = ~par_en;
        tif.PAR_TYP  = ~par_typ;
      end
      for (int c = 0; c < bit_len; c++)
        drive((b == spike_bit && c == spike_off) ? ~bits[b] : bits[b]);
    end
    tif.RX_IN = 1'b1;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check(name, exp_q.size(), 32'd0);
    repeat (20) drive(1'b1);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'hA5, 6'd8,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 8'hA5};
    vecs[1] = '{8'h3C, 6'd16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 8'h3C};
    vecs[2] = '{8'h3C, 6'd16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 8'h3C};
    vecs[3] = '{8'h81, 6'd32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 8'h3C};
    vecs[4] = '{8'hF0, 6'd16, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b011, 8'h3C};
    vecs[5] = '{8'h96, 6'd16, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'b100, 8'h96};
    vecs[6] = '{8'h4B, 6'd12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 8'h4B};
    vecs[7] = '{8'h00, 6'd32, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'b100, 8'h00};

    RST          = 1'b0;
    tif.RX_IN    = 1'b1;
    tif.PAR_EN   = 1'b0;
    tif.PAR_TYP  = 1'b0;
    tif.Prescale = 6'd8;
    #22;
    check("reset_pdata", {24'd0, tif.P_DATA}, 32'd0);
    check("reset_pulses", {29'd0, tif.Data_Valid, tif.Par_Err, tif.Stp_Err}, 32'd0);
    check("reset_state", 32'(dut.state_q), 32'(IDLE));
    RST = 1'b1;
    @(posedge CLK);
    #1;
    repeat (5) drive(1'b1);

    for (int i = 0; i < 8; i++) begin
      push(vecs[i].exp_flags, vecs[i].exp_pdata);
      send_frame(vecs[i].data, vecs[i].presc, vecs[i].par_en, vecs[i].par_typ,
                 vecs[i].bad_par, vecs[i].stop_bit, vecs[i].scramble, -1, -1);
      drain($sformatf("vec%0d_done", i), 100);
      check($sformatf("vec%0d_hold", i), {24'd0, tif.P_DATA}, {24'd0, vecs[i].exp_pdata});
    end
    last_good = 8'h00;

    // Short low glitch on an idle line must be rejected.
    tif.Prescale = 6'd16;
    drive(1'b0);
    drive(1'b0);
    repeat (40) drive(1'b1);
    check("glitch_state", 32'(dut.state_q), 32'(IDLE));
    check("glitch_pdata", {24'd0, tif.P_DATA}, {24'd0, last_good});

    // Single-cycle spike in the middle of data bit 3 is out-voted.
    push(3'b100, 8'h6D);
    send_frame(8'h6D, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4, 8);
    drain("spike_done", 100);
    check("spike_pdata", {24'd0, tif.P_DATA}, 32'h6D);

    // Three frames with no idle gap.
    push(3'b100, 8'h00);
    send_frame(8'h00, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
    push(3'b100, 8'hFF);
    send_frame(8'hFF, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
    push(3'b100, 8'h55);
    send_frame(8'h55, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
    drain("b2b_done", 100);
    check("b2b_pdata", {24'd0, tif.P_DATA}, 32'h55);

    // Reset in the middle of the data bits aborts the frame.
    tif.Prescale = 6'd8;
    repeat (8) drive(1'b0);
    repeat (8) drive(1'b1);
    repeat (8) drive(1'b1);
    repeat (4) drive(1'b0);
    RST = 1'b0;
    #1;
    check("midreset_pdata", {24'd0, tif.P_DATA}, 32'd0);
    check("midreset_pulses", {29'd0, tif.Data_Valid, tif.Par_Err, tif.Stp_Err}, 32'd0);
    check("midreset_state", 32'(dut.state_q), 32'(IDLE));
    tif.RX_IN = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;
    repeat (10) drive(1'b1);
    check("postreset_state", 32'(dut.state_q), 32'(IDLE));
    push(3'b100, 8'h5A);
    send_frame(8'h5A, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
    drain("postreset_done", 100);
    check("postreset_pdata", {24'd0, tif.P_DATA}, 32'h5A);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
